// File: rtl/drac_pkg.sv
// Shared types and constants for the Lagarto multi-hart reset sequencer.
// Holds the sequencer state encoding, legal parameter ranges and counter widths.
package drac_pkg;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_WAKE    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } seq_state_e;

    localparam int NUM_HARTS_MIN   = 1;
    localparam int NUM_HARTS_MAX   = 8;
    localparam int WAKE_CNT_W_MIN  = 2;
    localparam int WAKE_CNT_W_MAX  = 32;
    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;
    localparam int STAGGER_CYC_MIN = 1;
    localparam int STAGGER_CYC_MAX = 255;
    localparam int HOLD_CYC_MIN    = 1;
    localparam int HOLD_CYC_MAX    = 255;

    localparam int HOLD_CNT_W    = 8;
    localparam int STAGGER_CNT_W = 8;
    // Wide enough to hold NUM_HARTS_MAX itself, which marks "all harts released".
    localparam int HART_IDX_W    = 4;

endpackage

// File: rtl/lagarto_sync_chain.sv
// Multi-flop synchronizer for a single-bit signal of asynchronous origin.
// Clears to 0 on synchronous reset so downstream logic sees "not ready".
module lagarto_sync_chain #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] stages;

    always_ff @(posedge clk) begin
        if (rst) begin
            stages <= '0;
        end else begin
            stages <= {stages[DEPTH-2:0], d};
        end
    end

    assign q = stages[DEPTH-1];

endmodule

// File: rtl/lagarto_multi_reset_seq.sv
// Reset sequencer for a group of Lagarto harts: waits for the tile reset, runs a
// wake-up delay, releases harts one by one, then services per-hart soft resets.
module lagarto_multi_reset_seq
    import drac_pkg::*;
#(
    parameter int NUM_HARTS   = 2,
    parameter int WAKE_CNT_W  = 16,
    parameter int SYNC_STAGES = 2,
    parameter int STAGGER_CYC = 4,
    parameter int HOLD_CYC    = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 ext_rst_ni,
    input  logic [NUM_HARTS-1:0] soft_rst_req_i,
    output logic [NUM_HARTS-1:0] hart_rst_no,
    output logic [NUM_HARTS-1:0] soft_rst_ack_o,
    output logic                 all_run_o
);

    logic                     ext_ok;
    seq_state_e               state;
    logic [WAKE_CNT_W-1:0]    wake_cnt;
    logic [WAKE_CNT_W-1:0]    wake_nxt;
    logic [STAGGER_CNT_W-1:0] stagger_cnt;
    logic [HART_IDX_W-1:0]    rel_idx;
    logic [HOLD_CNT_W-1:0]    hold_cnt [NUM_HARTS];
    logic [HOLD_CNT_W-1:0]    hold_nxt [NUM_HARTS];
    logic [NUM_HARTS-1:0]     hart_nxt;
    logic [NUM_HARTS-1:0]     ack_nxt;
    logic                     stagger_done;
    logic                     all_released;

    lagarto_sync_chain #(
        .DEPTH(SYNC_STAGES)
    ) u_sync (
        .clk(clk_i),
        .rst(rst_i),
        .d  (ext_rst_ni),
        .q  (ext_ok)
    );

    assign wake_nxt     = (&wake_cnt) ? wake_cnt : wake_cnt + WAKE_CNT_W'(1);
    assign stagger_done = (stagger_cnt == STAGGER_CNT_W'(STAGGER_CYC - 1));
    assign all_released = (rel_idx == HART_IDX_W'(NUM_HARTS));

    // Next value of the per-hart reset lines, hold counters and acks; the FSM
    // below registers them and derives all_run_o from the same next values.
    always_comb begin
        hart_nxt = hart_rst_no;
        ack_nxt  = '0;
        for (int h = 0; h < NUM_HARTS; h++) begin
            hold_nxt[h] = hold_cnt[h];
        end
        if (!ext_ok) begin
            hart_nxt = '0;
            for (int h = 0; h < NUM_HARTS; h++) begin
                hold_nxt[h] = '0;
            end
        end else begin
            case (state)
                ST_HOLD: begin
                    hart_nxt = '0;
                end
                ST_WAKE: begin
                    hart_nxt    = '0;
                    hart_nxt[0] = wake_nxt[WAKE_CNT_W-1];
                end
                ST_RELEASE: begin
                    if (!all_released && stagger_done) begin
                        for (int h = 0; h < NUM_HARTS; h++) begin
                            if (HART_IDX_W'(h) == rel_idx) begin
                                hart_nxt[h] = 1'b1;
                            end
                        end
                    end
                end
                ST_RUN: begin
                    for (int h = 0; h < NUM_HARTS; h++) begin
                        if (hold_cnt[h] != '0) begin
                            hold_nxt[h] = hold_cnt[h] - HOLD_CNT_W'(1);
                            if (hold_cnt[h] == HOLD_CNT_W'(1)) begin
                                hart_nxt[h] = 1'b1;
                                ack_nxt[h]  = 1'b1;
                            end
                        end else if (soft_rst_req_i[h]) begin
                            hart_nxt[h] = 1'b0;
                            hold_nxt[h] = HOLD_CNT_W'(HOLD_CYC);
                        end
                    end
                end
                default: begin
                    hart_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= ST_HOLD;
            wake_cnt       <= '0;
            stagger_cnt    <= '0;
            rel_idx        <= '0;
            hart_rst_no    <= '0;
            soft_rst_ack_o <= '0;
            all_run_o      <= 1'b0;
            for (int h = 0; h < NUM_HARTS; h++) begin
                hold_cnt[h] <= '0;
            end
        end else begin
            hart_rst_no    <= hart_nxt;
            soft_rst_ack_o <= ack_nxt;
            all_run_o      <= 1'b0;
            for (int h = 0; h < NUM_HARTS; h++) begin
                hold_cnt[h] <= hold_nxt[h];
            end
            if (!ext_ok) begin
                state       <= ST_HOLD;
                wake_cnt    <= '0;
                stagger_cnt <= '0;
                rel_idx     <= '0;
            end else begin
                case (state)
                    ST_HOLD: begin
                        wake_cnt    <= '0;
                        stagger_cnt <= '0;
                        rel_idx     <= '0;
                        state       <= ST_WAKE;
                    end
                    ST_WAKE: begin
                        wake_cnt <= wake_nxt;
                        // Hart 0 goes out on the same edge that enters RELEASE.
                        if (wake_nxt[WAKE_CNT_W-1]) begin
                            state       <= ST_RELEASE;
                            rel_idx     <= HART_IDX_W'(1);
                            stagger_cnt <= '0;
                        end
                    end
                    ST_RELEASE: begin
                        if (all_released) begin
                            state <= ST_RUN;
                        end else if (stagger_done) begin
                            stagger_cnt <= '0;
                            rel_idx     <= rel_idx + HART_IDX_W'(1);
                        end else begin
                            stagger_cnt <= stagger_cnt + STAGGER_CNT_W'(1);
                        end
                    end
                    ST_RUN: begin
                        all_run_o <= &hart_nxt;
                    end
                    default: begin
                        state <= ST_HOLD;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lagarto_multi_reset_seq.sv
// Scoreboard bench: stimulus queues expected output transitions with their cycle,
// and per-DUT monitors pop and compare whenever the outputs change.
module tb_lagarto_multi_reset_seq;

    typedef struct {
        int         cyc;
        logic [7:0] hart;
        logic [7:0] ack;
        logic       run;
        string      name;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst2 = 1'b1;
    logic       ext2 = 1'b1;
    logic [1:0] req2 = '0;
    logic [1:0] hart2;
    logic [1:0] ack2;
    logic       run2;
    logic       rst8 = 1'b1;
    logic       ext8 = 1'b1;
    logic [7:0] req8 = '0;
    logic [7:0] hart8;
    logic [7:0] ack8;
    logic       run8;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic mon_en = 1'b0;
    logic armed2 = 1'b0;
    logic armed8 = 1'b0;
    logic [4:0]  cur2, prev2;
    logic [16:0] cur8, prev8;
    exp_t q2[$];
    exp_t q8[$];
    exp_t ev2, ev8;

    lagarto_multi_reset_seq #(
        .NUM_HARTS(2), .WAKE_CNT_W(4), .SYNC_STAGES(2), .STAGGER_CYC(4), .HOLD_CYC(8)
    ) dut2 (
        .clk_i(clk), .rst_i(rst2), .ext_rst_ni(ext2), .soft_rst_req_i(req2),
        .hart_rst_no(hart2), .soft_rst_ack_o(ack2), .all_run_o(run2)
    );

    lagarto_multi_reset_seq #(
        .NUM_HARTS(8), .WAKE_CNT_W(4), .SYNC_STAGES(2), .STAGGER_CYC(1), .HOLD_CYC(8)
    ) dut8 (
        .clk_i(clk), .rst_i(rst8), .ext_rst_ni(ext8), .soft_rst_req_i(req8),
        .hart_rst_no(hart8), .soft_rst_ack_o(ack8), .all_run_o(run8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic r2, input logic e2, input logic [1:0] s2,
                                 input logic r8, input logic e8, input logic [7:0] s8);
        @(negedge clk);
        rst2 = r2; ext2 = e2; req2 = s2;
        rst8 = r8; ext8 = e8; req8 = s8;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp2(input string n, input int c, input logic [1:0] h, input logic [1:0] a, input logic r);
        q2.push_back('{cyc: c, hart: {6'b0, h}, ack: {6'b0, a}, run: r, name: n});
    endtask

    task automatic push_exp8(input string n, input int c, input logic [7:0] h, input logic [7:0] a, input logic r);
        q8.push_back('{cyc: c, hart: h, ack: a, run: r, name: n});
    endtask

    // Monitor for the 2-hart instance: any output change must match the queue head.
    always @(negedge clk) begin
        if (mon_en) begin
            cur2 = {hart2, ack2, run2};
            if (!armed2) begin
                armed2 = 1'b1;
            end else if (cur2 !== prev2) begin
                if (q2.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL dut2 unexpected change at cycle %0d: hart=%b ack=%b run=%b",
                             cyc, hart2, ack2, run2);
                end else begin
                    ev2 = q2.pop_front();
                    checkOutput({ev2.name, " cycle"}, cyc, ev2.cyc);
                    checkOutput({ev2.name, " hart_rst_no"}, {30'b0, hart2}, {24'b0, ev2.hart});
                    checkOutput({ev2.name, " ack"}, {30'b0, ack2}, {24'b0, ev2.ack});
                    checkOutput({ev2.name, " all_run"}, {31'b0, run2}, {31'b0, ev2.run});
                end
            end
            prev2 = cur2;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            cur8 = {hart8, ack8, run8};
            if (!armed8) begin
                armed8 = 1'b1;
            end else if (cur8 !== prev8) begin
                if (q8.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL dut8 unexpected change at cycle %0d: hart=%b ack=%b run=%b",
                             cyc, hart8, ack8, run8);
                end else begin
                    ev8 = q8.pop_front();
                    checkOutput({ev8.name, " cycle"}, cyc, ev8.cyc);
                    checkOutput({ev8.name, " hart_rst_no"}, {24'b0, hart8}, {24'b0, ev8.hart});
                    checkOutput({ev8.name, " ack"}, {24'b0, ack8}, {24'b0, ev8.ack});
                    checkOutput({ev8.name, " all_run"}, {31'b0, run8}, {31'b0, ev8.run});
                end
            end
            prev8 = cur8;
        end
    end

    initial begin
        int b;
        wait_cycles(3);
        checkOutput("reset dut2 hart_rst_no", {30'b0, hart2}, 32'h0);
        checkOutput("reset dut2 ack", {30'b0, ack2}, 32'h0);
        checkOutput("reset dut2 all_run", {31'b0, run2}, 32'h0);
        checkOutput("reset dut8 hart_rst_no", {24'b0, hart8}, 32'h0);
        checkOutput("reset dut8 ack", {24'b0, ack8}, 32'h0);
        checkOutput("reset dut8 all_run", {31'b0, run8}, 32'h0);
        mon_en = 1'b1;
        wait_cycles(1);

        $display("[TB] staggered power-up release");
        applyStimulus(1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 8'h00);
        b = cyc;
        push_exp2("pwrup hart0", b + 11, 2'b01, 2'b00, 1'b0);
        push_exp2("pwrup hart1", b + 15, 2'b11, 2'b00, 1'b0);
        push_exp2("pwrup all_run", b + 17, 2'b11, 2'b00, 1'b1);
        wait_cycles(20);

        $display("[TB] single soft reset on hart1");
        applyStimulus(1'b0, 1'b1, 2'b10, 1'b1, 1'b1, 8'h00);
        b = cyc;
        push_exp2("soft1 hold", b + 1, 2'b01, 2'b00, 1'b0);
        push_exp2("soft1 release", b + 9, 2'b11, 2'b10, 1'b1);
        push_exp2("soft1 ack end", b + 10, 2'b11, 2'b00, 1'b1);
        applyStimulus(1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 8'h00);
        wait_cycles(12);

        $display("[TB] simultaneous soft resets");
        applyStimulus(1'b0, 1'b1, 2'b11, 1'b1, 1'b1, 8'h00);
        b = cyc;
        push_exp2("soft01 hold", b + 1, 2'b00, 2'b00, 1'b0);
        push_exp2("soft01 release", b + 9, 2'b11, 2'b11, 1'b1);
        push_exp2("soft01 ack end", b + 10, 2'b11, 2'b00, 1'b1);
        applyStimulus(1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 8'h00);
        wait_cycles(12);

        $display("[TB] request held across release retriggers");
        applyStimulus(1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 8'h00);
        b = cyc;
        push_exp2("retrig hold", b + 1, 2'b10, 2'b00, 1'b0);
        push_exp2("retrig release1", b + 9, 2'b11, 2'b01, 1'b1);
        push_exp2("retrig hold2", b + 10, 2'b10, 2'b00, 1'b0);
        push_exp2("retrig release2", b + 18, 2'b11, 2'b01, 1'b1);
        push_exp2("retrig ack end", b + 19, 2'b11, 2'b00, 1'b1);
        wait_cycles(9);
        applyStimulus(1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 8'h00);
        wait_cycles(12);

        $display("[TB] rst_i during soft-reset hold");
        applyStimulus(1'b0, 1'b1, 2'b10, 1'b1, 1'b1, 8'h00);
        b = cyc;
        push_exp2("rsthold hold", b + 1, 2'b01, 2'b00, 1'b0);
        push_exp2("rsthold reset", b + 4, 2'b00, 2'b00, 1'b0);
        push_exp2("rsthold hart0", b + 15, 2'b01, 2'b00, 1'b0);
        push_exp2("rsthold hart1", b + 19, 2'b11, 2'b00, 1'b0);
        push_exp2("rsthold all_run", b + 21, 2'b11, 2'b00, 1'b1);
        applyStimulus(1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 8'h00);
        wait_cycles(1);
        applyStimulus(1'b1, 1'b1, 2'b00, 1'b1, 1'b1, 8'h00);
        applyStimulus(1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 8'h00);
        wait_cycles(20);

        $display("[TB] tile reset dropped mid-release");
        applyStimulus(1'b1, 1'b1, 2'b00, 1'b1, 1'b1, 8'h00);
        b = cyc;
        push_exp2("extdrop reset", b + 1, 2'b00, 2'b00, 1'b0);
        push_exp2("extdrop hart0", b + 12, 2'b01, 2'b00, 1'b0);
        push_exp2("extdrop hold", b + 16, 2'b00, 2'b00, 1'b0);
        applyStimulus(1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 8'h00);
        wait_cycles(11);
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 8'h00);
        wait_cycles(4);
        applyStimulus(1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 8'h00);
        b = cyc;
        push_exp2("reacq hart0", b + 11, 2'b01, 2'b00, 1'b0);
        push_exp2("reacq hart1", b + 15, 2'b11, 2'b00, 1'b0);
        push_exp2("reacq all_run", b + 17, 2'b11, 2'b00, 1'b1);
        wait_cycles(20);

        $display("[TB] eight harts, back-to-back release");
        applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 8'hFF);
        b = cyc;
        for (int i = 0; i < 8; i++) begin
            push_exp8($sformatf("h8 release%0d", i), b + 11 + i, 8'((1 << (i + 1)) - 1), 8'h00, 1'b0);
        end
        push_exp8("h8 all_run", b + 20, 8'hFF, 8'h00, 1'b1);
        wait_cycles(9);
        applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 8'h00);
        wait_cycles(12);

        applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 8'h81);
        b = cyc;
        push_exp8("h8 soft hold", b + 1, 8'h7E, 8'h00, 1'b0);
        push_exp8("h8 soft release", b + 9, 8'hFF, 8'h81, 1'b1);
        push_exp8("h8 soft ack end", b + 10, 8'hFF, 8'h00, 1'b1);
        applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 8'h00);
        wait_cycles(14);

        checkOutput("dut2 events never seen", q2.size(), 32'd0);
        checkOutput("dut8 events never seen", q8.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
